// File: rtl/tapasco_axi.sv
// AXI4 channel and bundle types shared across the tapasco_axi interconnect.
// Slave-side bundles carry one extra ID bit compared to the master side.
package tapasco_axi;

    localparam int unsigned IdWidth       = 4;
    localparam int unsigned IdWidthSlv    = 5;
    localparam int unsigned AddrWidth     = 32;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned UserWidth     = 1;
    localparam int unsigned NumRemapSlots = 2**IdWidth;

    typedef logic [IdWidth-1:0]      id_t;
    typedef logic [IdWidthSlv-1:0]   id_slv_t;
    typedef logic [AddrWidth-1:0]    addr_t;
    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [DataWidth/8-1:0]  strb_t;
    typedef logic [UserWidth-1:0]    user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_slv_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_slv_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_slv_t    id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_slv_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        id_slv_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_slv_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef struct packed {
        aw_chan_slv_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        ar_chan_slv_t ar;
        logic         ar_valid;
        logic         r_ready;
    } req_slv_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        b_chan_slv_t b;
        logic        r_valid;
        r_chan_slv_t r;
    } resp_slv_t;

endpackage

// File: rtl/tapasco_axi_id_remap_pkg.sv
// Channel conversion helpers for the ID remapper: swap the ID field between
// the 5-bit slave and 4-bit master widths, copying every other field.
package tapasco_axi_id_remap_pkg;

    import tapasco_axi::*;

    function automatic aw_chan_t remap_aw(input aw_chan_slv_t a, input id_t id);
        aw_chan_t m;
        m.id     = id;
        m.addr   = a.addr;
        m.len    = a.len;
        m.size   = a.size;
        m.burst  = a.burst;
        m.lock   = a.lock;
        m.cache  = a.cache;
        m.prot   = a.prot;
        m.qos    = a.qos;
        m.region = a.region;
        m.atop   = a.atop;
        m.user   = a.user;
        return m;
    endfunction

    function automatic ar_chan_t remap_ar(input ar_chan_slv_t a, input id_t id);
        ar_chan_t m;
        m.id     = id;
        m.addr   = a.addr;
        m.len    = a.len;
        m.size   = a.size;
        m.burst  = a.burst;
        m.lock   = a.lock;
        m.cache  = a.cache;
        m.prot   = a.prot;
        m.qos    = a.qos;
        m.region = a.region;
        m.user   = a.user;
        return m;
    endfunction

    function automatic b_chan_slv_t restore_b(input b_chan_t b, input id_slv_t id);
        b_chan_slv_t s;
        s.id   = id;
        s.resp = b.resp;
        s.user = b.user;
        return s;
    endfunction

    function automatic r_chan_slv_t restore_r(input r_chan_t r, input id_slv_t id);
        r_chan_slv_t s;
        s.id   = id;
        s.data = r.data;
        s.resp = r.resp;
        s.last = r.last;
        s.user = r.user;
        return s;
    endfunction

endpackage

// File: rtl/tapasco_axi_id_remap_table.sv
// One direction's remap table: slot selection, per-slot outstanding counters,
// response ID lookup and the hold register that pins a slot while stalled.
module tapasco_axi_id_remap_table
    import tapasco_axi::*;
#(
    parameter int unsigned MaxTxnsPerId = 8
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    req_valid_i,
    input  id_slv_t req_id_i,
    input  logic    req_ready_i,
    input  logic    rel_valid_i,
    input  id_t     rel_idx_i,
    output id_t     slot_o,
    output logic    stall_o,
    output id_slv_t slv_id_o,
    output logic    all_free_o
);

    localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

    id_slv_t           slv_id_q [NumRemapSlots];
    logic [CntW-1:0]   cnt_q    [NumRemapSlots];
    logic              hold_valid_q;
    id_t               hold_slot_q;

    logic              match_found, free_found, alloc_hs, hold_set;
    id_t               match_idx, free_idx;
    logic [NumRemapSlots-1:0] inc, dec;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        all_free_o  = 1'b1;
        for (int unsigned i = 0; i < NumRemapSlots; i++) begin
            if (cnt_q[i] != '0) begin
                all_free_o = 1'b0;
                if (!match_found && slv_id_q[i] == req_id_i) begin
                    match_found = 1'b1;
                    match_idx   = id_t'(i);
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = id_t'(i);
            end
        end

        slot_o  = '0;
        stall_o = 1'b0;
        if (hold_valid_q) begin
            slot_o = hold_slot_q;
        end else if (match_found) begin
            slot_o  = match_idx;
            stall_o = (cnt_q[match_idx] >= CntMax);
        end else if (free_found) begin
            slot_o = free_idx;
        end else begin
            stall_o = 1'b1;
        end
    end

    // A release on an empty slot is ignored so the counter never wraps.
    always_comb begin
        alloc_hs = req_valid_i && !stall_o && req_ready_i;
        hold_set = req_valid_i && !stall_o && !req_ready_i;
        for (int unsigned i = 0; i < NumRemapSlots; i++) begin
            inc[i] = alloc_hs && (slot_o == id_t'(i));
            dec[i] = rel_valid_i && (rel_idx_i == id_t'(i)) && (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_slot_q  <= '0;
            for (int unsigned i = 0; i < NumRemapSlots; i++) begin
                slv_id_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            hold_valid_q <= hold_set;
            if (hold_set) hold_slot_q <= slot_o;
            for (int unsigned i = 0; i < NumRemapSlots; i++) begin
                if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + CntW'(1);
                else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - CntW'(1);
                if (inc[i]) slv_id_q[i] <= req_id_i;
            end
        end
    end

    assign slv_id_o = slv_id_q[rel_idx_i];

    release_on_empty_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rel_valid_i |-> cnt_q[rel_idx_i] != '0);

endmodule

// File: rtl/tapasco_axi_id_remap.sv
// Remaps 5-bit slave AXI IDs onto 16 master IDs per direction and restores them
// on B/R. Optional stall counters are enabled by TAPASCO_ID_REMAP_PERF_EN.
module tapasco_axi_id_remap
    import tapasco_axi::*;
    import tapasco_axi_id_remap_pkg::*;
#(
    parameter int unsigned MaxTxnsPerId = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  req_slv_t    slv_req_i,
    output resp_slv_t   slv_resp_o,
    output req_t        mst_req_o,
    input  resp_t       mst_resp_i,
`ifdef TAPASCO_ID_REMAP_PERF_EN
    output logic [31:0] aw_stall_cnt_o,
    output logic [31:0] ar_stall_cnt_o,
`endif
    output logic        idle_o
);

    id_t     wr_slot, rd_slot;
    logic    wr_stall, rd_stall;
    id_slv_t wr_slv_id, rd_slv_id;
    logic    wr_all_free, rd_all_free;

    tapasco_axi_id_remap_table #(.MaxTxnsPerId(MaxTxnsPerId)) i_wr_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (slv_req_i.aw_valid),
        .req_id_i    (slv_req_i.aw.id),
        .req_ready_i (mst_resp_i.aw_ready),
        .rel_valid_i (mst_resp_i.b_valid && slv_req_i.b_ready),
        .rel_idx_i   (mst_resp_i.b.id),
        .slot_o      (wr_slot),
        .stall_o     (wr_stall),
        .slv_id_o    (wr_slv_id),
        .all_free_o  (wr_all_free)
    );

    tapasco_axi_id_remap_table #(.MaxTxnsPerId(MaxTxnsPerId)) i_rd_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (slv_req_i.ar_valid),
        .req_id_i    (slv_req_i.ar.id),
        .req_ready_i (mst_resp_i.ar_ready),
        .rel_valid_i (mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last),
        .rel_idx_i   (mst_resp_i.r.id),
        .slot_o      (rd_slot),
        .stall_o     (rd_stall),
        .slv_id_o    (rd_slv_id),
        .all_free_o  (rd_all_free)
    );

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = remap_aw(slv_req_i.aw, wr_slot);
        mst_req_o.aw_valid = slv_req_i.aw_valid && !wr_stall;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar       = remap_ar(slv_req_i.ar, rd_slot);
        mst_req_o.ar_valid = slv_req_i.ar_valid && !rd_stall;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !wr_stall;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !rd_stall;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.b        = restore_b(mst_resp_i.b, wr_slv_id);
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
        slv_resp_o.r        = restore_r(mst_resp_i.r, rd_slv_id);
    end

    assign idle_o = wr_all_free && rd_all_free;

`ifdef TAPASCO_ID_REMAP_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_stall_cnt_o <= '0;
            ar_stall_cnt_o <= '0;
        end else begin
            if (slv_req_i.aw_valid && wr_stall && aw_stall_cnt_o != '1)
                aw_stall_cnt_o <= aw_stall_cnt_o + 32'd1;
            if (slv_req_i.ar_valid && rd_stall && ar_stall_cnt_o != '1)
                ar_stall_cnt_o <= ar_stall_cnt_o + 32'd1;
        end
    end
`endif

    // Atomics with a read response would need an R-side slot; not supported.
    atop_read_unsupported: assert property (@(posedge clk_i) disable iff (!rst_ni)
        slv_req_i.aw_valid |-> !slv_req_i.aw.atop[5]);

endmodule

// File: tb/tb_tapasco_axi_id_remap.sv
// Directed bench for tapasco_axi_id_remap: stimulus pushes expected remapped
// requests and restored responses into queues checked by channel monitors.
module tb_tapasco_axi_id_remap;
    import tapasco_axi::*;

    logic      clk_i = 1'b0;
    logic      rst_ni = 1'b0;
    req_slv_t  slv_req;
    resp_slv_t slv_resp;
    req_t      mst_req;
    resp_t     mst_resp;
    logic      idle;
`ifdef TAPASCO_ID_REMAP_PERF_EN
    logic [31:0] aw_stall_cnt, ar_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [5:0] atop; } exp_ax_t;
    typedef struct { logic [4:0] id; logic [1:0] resp; } exp_b_t;
    typedef struct { logic [4:0] id; logic [31:0] data; logic last; } exp_r_t;

    exp_ax_t aw_q[$];
    exp_ax_t ar_q[$];
    exp_b_t  b_q[$];
    exp_r_t  r_q[$];

    tapasco_axi_id_remap dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
`ifdef TAPASCO_ID_REMAP_PERF_EN
        .aw_stall_cnt_o (aw_stall_cnt),
        .ar_stall_cnt_o (ar_stall_cnt),
`endif
        .idle_o     (idle)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk_i) begin
        exp_ax_t e;
        if (rst_ni && mst_req.aw_valid && mst_resp.aw_ready) begin
            if (aw_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL aw_unexpected: got id %0h expected none", mst_req.aw.id);
            end else begin
                e = aw_q.pop_front();
                check("aw_id", 32'(mst_req.aw.id), 32'(e.id));
                check("aw_addr", mst_req.aw.addr, e.addr);
                check("aw_atop", 32'(mst_req.aw.atop), 32'(e.atop));
            end
        end
    end

    always @(negedge clk_i) begin
        exp_ax_t e;
        if (rst_ni && mst_req.ar_valid && mst_resp.ar_ready) begin
            if (ar_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ar_unexpected: got id %0h expected none", mst_req.ar.id);
            end else begin
                e = ar_q.pop_front();
                check("ar_id", 32'(mst_req.ar.id), 32'(e.id));
                check("ar_addr", mst_req.ar.addr, e.addr);
            end
        end
    end

    always @(negedge clk_i) begin
        exp_b_t e;
        if (rst_ni && slv_resp.b_valid && slv_req.b_ready) begin
            if (b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: got id %0h expected none", slv_resp.b.id);
            end else begin
                e = b_q.pop_front();
                check("b_id", 32'(slv_resp.b.id), 32'(e.id));
                check("b_resp", 32'(slv_resp.b.resp), 32'(e.resp));
            end
        end
    end

    always @(negedge clk_i) begin
        exp_r_t e;
        if (rst_ni && slv_resp.r_valid && slv_req.r_ready) begin
            if (r_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: got id %0h expected none", slv_resp.r.id);
            end else begin
                e = r_q.pop_front();
                check("r_id", 32'(slv_resp.r.id), 32'(e.id));
                check("r_data", slv_resp.r.data, e.data);
                check("r_last", 32'(slv_resp.r.last), 32'(e.last));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_aw(input logic [4:0] id, input logic [31:0] addr,
                         input logic [5:0] atop, input logic [3:0] exp_id);
        int n;
        aw_q.push_back(exp_ax_t'{exp_id, addr, atop});
        slv_req.aw.id   = id;
        slv_req.aw.addr = addr;
        slv_req.aw.atop = atop;
        slv_req.aw_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (slv_resp.aw_ready) break;
        end
        if (n == 200) begin
            checks++; failures++;
            $display("FAIL aw_timeout: got no ready expected handshake for id %0h", id);
        end
        @(posedge clk_i); #1;
        slv_req.aw_valid = 1'b0;
    endtask

    task automatic do_ar(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] exp_id);
        int n;
        ar_q.push_back(exp_ax_t'{exp_id, addr, 6'h0});
        slv_req.ar.id   = id;
        slv_req.ar.addr = addr;
        slv_req.ar_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (slv_resp.ar_ready) break;
        end
        if (n == 200) begin
            checks++; failures++;
            $display("FAIL ar_timeout: got no ready expected handshake for id %0h", id);
        end
        @(posedge clk_i); #1;
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] mid, input logic [4:0] exp_id, input logic [1:0] resp);
        b_q.push_back(exp_b_t'{exp_id, resp});
        mst_resp.b.id   = mid;
        mst_resp.b.resp = resp;
        mst_resp.b_valid = 1'b1;
        @(posedge clk_i); #1;
        mst_resp.b_valid = 1'b0;
    endtask

    task automatic do_r(input logic [3:0] mid, input logic [4:0] exp_id,
                        input logic [31:0] data, input logic last);
        r_q.push_back(exp_r_t'{exp_id, data, last});
        mst_resp.r.id   = mid;
        mst_resp.r.data = data;
        mst_resp.r.last = last;
        mst_resp.r_valid = 1'b1;
        @(posedge clk_i); #1;
        mst_resp.r_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;

        // Reset: empty tables, AW valid passes straight through.
        slv_req.aw_valid = 1'b1;
        @(negedge clk_i);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_aw_valid_follows", 32'(mst_req.aw_valid), 32'd1);
        check("reset_aw_id", 32'(mst_req.aw.id), 32'd0);
        slv_req.aw_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Single write and its B response.
        do_aw(5'h13, 32'h0000_1000, 6'h0, 4'h0);
        check("t1_busy", 32'(idle), 32'd0);
        do_b(4'h0, 5'h13, 2'b00);
        check("t1_idle_after_b", 32'(idle), 32'd1);

        // W channel pass-through with downstream backpressure.
        slv_req.w.data = 32'hA5A5_5A5A;
        slv_req.w.last = 1'b1;
        slv_req.w_valid = 1'b1;
        mst_resp.w_ready = 1'b0;
        #1;
        check("w_data", mst_req.w.data, 32'hA5A5_5A5A);
        check("w_valid", 32'(mst_req.w_valid), 32'd1);
        check("w_ready", 32'(slv_resp.w_ready), 32'd0);
        slv_req.w_valid = 1'b0;
        mst_resp.w_ready = 1'b1;
        @(posedge clk_i); #1;

        // Same-ID ARs share slot 0, a new ID takes slot 1; only last beats release.
        for (int i = 0; i < 3; i++) do_ar(5'h07, 32'h2000 + 32'(i) * 32'h100, 4'h0);
        do_ar(5'h1A, 32'h0000_3000, 4'h1);
        do_r(4'h1, 5'h1A, 32'h0000_1A1A, 1'b1);
        for (int b = 0; b < 3; b++) begin
            for (int beat = 0; beat < 4; beat++)
                do_r(4'h0, 5'h07, 32'(b * 16 + beat), beat == 3);
            check("t2_idle_after_burst", 32'(idle), (b == 2) ? 32'd1 : 32'd0);
        end

        // Fill all 16 write slots; the 17th ID stalls until slot 5 is released.
        for (int i = 0; i < 16; i++) do_aw(5'(i), 32'h4000 + 32'(i) * 4, 6'h0, 4'(i));
        fork
            do_aw(5'h10, 32'h0000_4100, 6'h0, 4'h5);
            begin
                repeat (3) begin
                    @(negedge clk_i);
                    check("t3_full_aw_ready", 32'(slv_resp.aw_ready), 32'd0);
                    check("t3_full_mst_valid", 32'(mst_req.aw_valid), 32'd0);
                end
                @(posedge clk_i); #1;
                do_b(4'h5, 5'h05, 2'b01);
            end
        join
        for (int i = 0; i < 16; i++) do_b(4'(i), (i == 5) ? 5'h10 : 5'(i), 2'(i));
        check("t3_idle", 32'(idle), 32'd1);

        // Per-ID limit: the ninth AR with ID 2 waits for one R last.
        for (int i = 0; i < 8; i++) do_ar(5'h02, 32'h5000 + 32'(i), 4'h0);
        fork
            do_ar(5'h02, 32'h0000_5100, 4'h0);
            begin
                repeat (2) begin
                    @(negedge clk_i);
                    check("t4_limit_ar_ready", 32'(slv_resp.ar_ready), 32'd0);
                end
                @(posedge clk_i); #1;
                do_r(4'h0, 5'h02, 32'h0000_0200, 1'b1);
            end
        join
        for (int i = 0; i < 8; i++) do_r(4'h0, 5'h02, 32'h0000_0201 + 32'(i), 1'b1);
        check("t4_idle", 32'(idle), 32'd1);

        // Pending AW keeps its slot while a B frees a lower one.
        do_aw(5'h01, 32'h0000_6000, 6'h0, 4'h0);
        do_aw(5'h02, 32'h0000_6004, 6'h0, 4'h1);
        mst_resp.aw_ready = 1'b0;
        fork
            do_aw(5'h03, 32'h0000_6008, 6'h0, 4'h2);
            begin
                @(negedge clk_i);
                check("t5_id_before", 32'(mst_req.aw.id), 32'd2);
                check("t5_valid_before", 32'(mst_req.aw_valid), 32'd1);
                @(posedge clk_i); #1;
                do_b(4'h0, 5'h01, 2'b00);
                @(negedge clk_i);
                check("t5_id_held", 32'(mst_req.aw.id), 32'd2);
                @(posedge clk_i); #1;
                mst_resp.aw_ready = 1'b1;
            end
        join
        do_b(4'h1, 5'h02, 2'b00);
        do_b(4'h2, 5'h03, 2'b00);
        check("t5_idle", 32'(idle), 32'd1);

        // Simultaneous allocate and release on slot 3 leaves its count at 2.
        do_ar(5'h0A, 32'h0000_7000, 4'h0);
        do_ar(5'h0B, 32'h0000_7004, 4'h1);
        do_ar(5'h0C, 32'h0000_7008, 4'h2);
        do_ar(5'h0D, 32'h0000_700C, 4'h3);
        do_ar(5'h0D, 32'h0000_7010, 4'h3);
        fork
            do_ar(5'h0D, 32'h0000_7014, 4'h3);
            do_r(4'h3, 5'h0D, 32'h0000_0D00, 1'b1);
        join
        do_r(4'h0, 5'h0A, 32'h0000_0A00, 1'b1);
        do_r(4'h1, 5'h0B, 32'h0000_0B00, 1'b1);
        do_r(4'h2, 5'h0C, 32'h0000_0C00, 1'b1);
        check("t6_busy_slot3", 32'(idle), 32'd0);
        do_r(4'h3, 5'h0D, 32'h0000_0D01, 1'b1);
        check("t6_cnt_one_left", 32'(idle), 32'd0);
        do_r(4'h3, 5'h0D, 32'h0000_0D02, 1'b1);
        check("t6_idle", 32'(idle), 32'd1);

        // Atomic without read response goes through the write table unchanged.
        do_aw(5'h05, 32'h0000_8000, 6'h10, 4'h0);
        check("atop_busy", 32'(idle), 32'd0);
        do_b(4'h0, 5'h05, 2'b10);
        check("atop_idle", 32'(idle), 32'd1);

        repeat (2) @(posedge clk_i);
        check("aw_q_drained", 32'(aw_q.size()), 32'd0);
        check("ar_q_drained", 32'(ar_q.size()), 32'd0);
        check("b_q_drained", 32'(b_q.size()), 32'd0);
        check("r_q_drained", 32'(r_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tapasco_axi_id_remap.md
Name: tapasco_axi_id_remap

Overview:
- Sits between the 5-bit-ID slave-side AXI4 port (req_slv_t/resp_slv_t) and the 4-bit-ID master-side port (req_t/resp_t) of the tapasco_axi interconnect.
- Compresses slave IDs into a 16-entry master ID space per direction, tracks outstanding transactions, and restores the original ID on B and R responses.
- Same-ID ordering is preserved by reusing the slot that already holds a given slave ID.
- All channels are combinational pass-through, zero latency; only the ID tables and the hold registers are sequential.

Parameters:
- MaxTxnsPerId, 8: maximum outstanding transactions per remap slot; counter width CntW = $clog2(MaxTxnsPerId+1).
- NumSlots, 2**tapasco_axi::IdWidth (16): remap slots per direction; fixed by the package, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_req_i  in  tapasco_axi::req_slv_t  upstream request, 5-bit IDs
- slv_resp_o  out  tapasco_axi::resp_slv_t  upstream response, restored 5-bit IDs
- mst_req_o  out  tapasco_axi::req_t  downstream request, 4-bit remapped IDs
- mst_resp_i  in  tapasco_axi::resp_t  downstream response, 4-bit IDs
- idle_o  out  1  high when every slot in both tables has count 0

Behaviour:
- Two independent tables, write (AW/B) and read (AR/R). Each slot holds: slv_id[4:0], cnt[CntW-1:0]. A slot is free when cnt==0.
- Reset (async, rst_ni low): all cnt=0, slv_id=0, hold registers invalid, idle_o=1.
  - Outputs are combinational; with empty tables mst aw/ar_valid follow slv valid.
  - A transaction in flight at reset is dropped; no recovery.
- Slot select (per AW/AR request), first matching rule wins:
  - (a) Hold register valid: use the held slot.
  - (b) A slot with cnt>0 and slv_id==req id exists: use that slot if cnt<MaxTxnsPerId, otherwise stall.
  - (c) No match: use the lowest-index free slot.
  - (d) No free slot: stall.
- Stall: mst x_valid=0 and slv x_ready=0.
- No stall:
  - mst x_valid = slv x_valid; mst id = slot index; all other fields copied unchanged.
  - slv x_ready = mst x_ready.
- Stability: if mst x_valid=1 and mst x_ready=0, register the chosen slot in the hold register. The slot stays fixed until the handshake, even if responses free or change other slots. Clear the hold register on handshake.
- Allocation on handshake: slot.slv_id <= req id; cnt <= cnt+1.
- W channel: pure pass-through, w_valid/w_ready/payload unchanged. W-before-AW is permitted.
- B return:
  - slv b.id = write_table[mst b.id].slv_id; resp and user copied.
  - cnt decrements on b_valid&&b_ready.
- R return:
  - slv r.id = read_table[mst r.id].slv_id.
  - cnt decrements on r_valid&&r_ready&&r.last.
  - Beats without last do not change cnt.
- Simultaneous allocate and release on the same slot in one cycle: cnt unchanged.
- A response whose slot has cnt==0 is a protocol error. cnt must not underflow (saturate at 0); a simulation assertion fires.
- ATOPs: aw.atop!=0 is forwarded as a plain write (write table only). atop[5]=1 (read response) is unsupported; an assertion fires.
- idle_o is combinational from the counters.

Optional Feature:
- TAPASCO_ID_REMAP_PERF_EN defined: adds outputs aw_stall_cnt_o[31:0] and ar_stall_cnt_o[31:0].
  - Each increments on every cycle where slv x_valid=1 and the slot-select logic stalls.
  - Each saturates at 32'hFFFF_FFFF; reset to 0.
- Not defined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- tapasco_axi package gets: localparam NumRemapSlots = 2**IdWidth; typedef remap_entry_t {id_slv_t slv_id; cnt} with cnt width passed via a parameter struct. Alternatively, keep cnt generic inside the module.
- One sub-module, tapasco_axi_id_remap_table, instantiated twice (write, read).
  - Inputs: alloc request id/valid/handshake, release index/handshake.
  - Outputs: selected slot, stall, looked-up slv_id, all-free flag.
  - Contains the hold register.

Test Plan:
- Single write, slave id 5'h13 -> mst aw.id=4'h0. B returned with id 4'h0 -> slv b.id=5'h13; idle_o returns to 1 the cycle after the B handshake.
- Three ARs with slave id 5'h07 then one with 5'h1A -> ids 0,0,0,1. R bursts len=3 on id 0 -> cnt decrements only on last beats; slot 0 is freed after the third last.
- 17 distinct slave AW ids with no B responses -> first 16 get ids 0..15. The 17th stalls (aw_ready=0) until any B frees a slot, then takes that slot index.
- 9 ARs with id 5'h02 and MaxTxnsPerId=8 -> the 9th stalls until one R last returns; then it is accepted on slot 0.
- AW pending with mst aw_ready=0 while a B frees a lower slot -> mst aw.id stays unchanged until the handshake.
- Same-cycle AR handshake on slot 3 and R last on slot 3 with cnt=2 -> cnt stays 2.
